// File: rtl/win3x3_gen_fp16_if.sv
// ----------------------------------------------------------------------------
// win3x3_gen_fp16_if
//   Stream bundle for the 3x3 window generator.
//   Pixel side : in_valid / in_ready / in_pix   (producer -> generator)
//   Window side: out_valid / out_ready / out_win (generator -> consumer)
//   master : the environment (drives pixels, consumes windows)
//   slave  : the window generator
// ----------------------------------------------------------------------------
interface win3x3_gen_fp16_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_pix;
  logic                 out_valid;
  logic                 out_ready;
  logic [8:0][DW-1:0]   out_win;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_win
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_win
  );
endinterface

// File: rtl/win3x3_gen_fp16.sv
// ----------------------------------------------------------------------------
// win3x3_gen_fp16
//   Streaming 3x3 sliding-window generator (valid padding, stride 1) for FP16
//   feature maps. Pixels are opaque DW-bit patterns arriving in row-major
//   order; two line buffers hold the previous two rows. One registered
//   window is emitted per valid position, one cycle after the accept of its
//   bottom-right pixel.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     start               begin a frame (sampled only in IDLE with no
//                         pending window)
//     cfg_width/height    frame size, latched when start is accepted
//     strm (slave)        pixel in / window out valid-ready streams
//                         out_win[3*r+c], r=0 top (oldest) row, c=0 leftmost
//     busy                high while a frame is being received
//     frame_done          pulse the cycle after the last pixel is accepted
//     cfg_err             pulse the cycle after a start with bad size
// ----------------------------------------------------------------------------
module win3x3_gen_fp16 #(
  parameter  int MAX_W = 64,
  parameter  int MAX_H = 64,
  parameter  int DW    = 16,
  localparam int CW    = $clog2(MAX_W + 1),
  localparam int RW    = $clog2(MAX_H + 1),
  localparam int AW    = $clog2(MAX_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CW-1:0]           cfg_width,
  input  logic [RW-1:0]           cfg_height,
  win3x3_gen_fp16_if.slave        strm,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    cfg_err
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       width_q, width_d;
  logic [RW-1:0]       height_q, height_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                out_valid_q, out_valid_d;
  logic [8:0][DW-1:0]  win_q, win_d;
  logic                frame_done_q, frame_done_d;
  logic                cfg_err_q, cfg_err_d;

  // lb1 holds row-2, lb0 holds row-1 at the current column.
  logic [DW-1:0]       lb0_q [MAX_W];
  logic [DW-1:0]       lb1_q [MAX_W];

  logic                in_ready;
  logic                accept;
  logic                cfg_ok;
  logic                last_col;
  logic                last_row;
  logic [AW-1:0]       col_idx;

  // A pixel may only enter when the output register is free or being drained
  // this same cycle, so a stalled window is never overwritten.
  assign in_ready = (state_q == RUN) && (!out_valid_q || strm.out_ready);
  assign accept   = strm.in_valid && in_ready;
  assign cfg_ok   = (cfg_width  >= CW'(3)) && (cfg_width  <= CW'(MAX_W)) &&
                    (cfg_height >= RW'(3)) && (cfg_height <= RW'(MAX_H));
  assign last_col = (col_q == width_q  - CW'(1));
  assign last_row = (row_q == height_q - RW'(1));
  assign col_idx  = col_q[AW-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    row_d        = row_q;
    col_d        = col_q;
    out_valid_d  = out_valid_q;
    win_d        = win_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;

    if (out_valid_q && strm.out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A pending window from the previous frame must drain first.
        if (start && !out_valid_q) begin
          if (cfg_ok) begin
            state_d  = RUN;
            width_d  = cfg_width;
            height_d = cfg_height;
            row_d    = '0;
            col_d    = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
          end
          // Line buffers are read before this cycle's write lands.
          win_d[2] = lb1_q[col_idx];
          win_d[5] = lb0_q[col_idx];
          win_d[8] = strm.in_pix;

          out_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));

          if (last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (last_row) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      win_q        <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      win_q        <= win_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // NOTE: line-buffer memories carry no reset; a window is only flagged valid
  // once two full rows of the current frame have been written, so stale
  // contents are never observed and the arrays can map to RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_idx] <= lb0_q[col_idx];
      lb0_q[col_idx] <= strm.in_pix;
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_win   = win_q;
  assign busy           = (state_q == RUN);
  assign frame_done     = frame_done_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_win3x3_gen_fp16.sv
// ----------------------------------------------------------------------------
// tb_win3x3_gen_fp16
//   Self-checking bench for win3x3_gen_fp16. A reference image model builds
//   the expected window whenever a pixel is accepted at a valid position and
//   queues it; the monitor pops and compares on every window handshake.
// ----------------------------------------------------------------------------
module tb_win3x3_gen_fp16;
  localparam int MAX_W = 64;
  localparam int MAX_H = 64;
  localparam int DW    = 16;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam int RW    = $clog2(MAX_H + 1);

  typedef logic [8:0][DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_width;
  logic [RW-1:0] cfg_height;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;

  win3x3_gen_fp16_if #(.DW(DW)) s ();

  win3x3_gen_fp16 #(.MAX_W(MAX_W), .MAX_H(MAX_H), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .strm      (s),
    .busy      (busy),
    .frame_done(frame_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            win_cnt  = 0;
  win_t          sb [$];
  logic [DW-1:0] img [MAX_H][MAX_W];

  task automatic check(input string tag, input logic [143:0] got,
                       input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every window handshake must match the oldest
  // expected window.
  always @(negedge clk) begin
    if (rst_n && s.out_valid && s.out_ready) begin
      win_cnt++;
      if (sb.size() == 0) check("sb_unexpected_win", 144'(sb.size()), 144'd1);
      else check("win", s.out_win, sb.pop_front());
    end
  end

  task automatic send_pix(input logic [DW-1:0] v, input int r, input int c);
    bit   ok;
    win_t e;
    ok         = 1'b0;
    s.in_valid = 1'b1;
    s.in_pix   = v;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (s.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("in_ready_timeout", 144'(ok), 144'd1);
      s.in_valid = 1'b0;
      return;
    end
    img[r][c] = v;
    if (r >= 2 && c >= 2) begin
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          e[3*rr+cc] = img[r-2+rr][c-2+cc];
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int w, input int h);
    cfg_width  = CW'(w);
    cfg_height = RW'(h);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_busy", 144'(busy), 144'd1);
    check("start_no_err", 144'(cfg_err), 144'd0);
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input int w, input int h);
    cfg_width  = CW'(w);
    cfg_height = RW'(h);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("bad_cfg_err", 144'(cfg_err), 144'd1);
    check("bad_busy", 144'(busy), 144'd0);
    check("bad_in_ready", 144'(s.in_ready), 144'd0);
    @(negedge clk);
    check("bad_cfg_err_once", 144'(cfg_err), 144'd0);
    check("bad_busy2", 144'(busy), 144'd0);
    @(posedge clk); #1;
  endtask

  // mode 0: p = linear index, mode 1: random. mid_start pulses start after
  // the third pixel with a different (legal) size, which must be ignored.
  task automatic run_frame(input int w, input int h, input int mode,
                           input bit mid_start);
    int idx;
    idx = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        send_pix(mode == 0 ? DW'(idx) : DW'($urandom), r, c);
        idx++;
        if (mid_start && idx == 3) begin
          s.in_valid = 1'b0;
          cfg_width  = CW'(5);
          cfg_height = RW'(5);
          start      = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          @(negedge clk);
          check("mid_start_busy", 144'(busy), 144'd1);
          check("mid_start_no_err", 144'(cfg_err), 144'd0);
          @(posedge clk); #1;
        end
      end
    end
    s.in_valid = 1'b0;
    @(negedge clk);
    check("frame_done", 144'(frame_done), 144'd1);
    check("done_idle", 144'(busy), 144'd0);
    @(posedge clk); #1;
    check("frame_done_pulse", 144'(frame_done), 144'd0);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !s.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 144'(sb.size()), 144'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   base;
    bit   drv_done;
    bit   seen;
    win_t first_win;

    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        first_win[3*rr+cc] = DW'(rr * 4 + cc);

    rst_n       = 1'b0;
    start       = 1'b0;
    cfg_width   = '0;
    cfg_height  = '0;
    s.in_valid  = 1'b0;
    s.in_pix    = '0;
    s.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 144'(s.out_valid), 144'd0);
    check("rst_in_ready", 144'(s.in_ready), 144'd0);
    check("rst_busy", 144'(busy), 144'd0);
    check("rst_frame_done", 144'(frame_done), 144'd0);
    check("rst_cfg_err", 144'(cfg_err), 144'd0);
    check("rst_out_win", s.out_win, 144'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 144'(s.in_ready), 144'd0);

    // T1: 4x4 linear frame, consumer always ready.
    base = win_cnt;
    do_start(4, 4);
    run_frame(4, 4, 0, 1'b0);
    wait_drain();
    check("t1_wins", 144'(win_cnt - base), 144'd4);

    // T2: consumer stalls 5 cycles on the first window.
    base        = win_cnt;
    s.out_ready = 1'b0;
    do_start(4, 4);
    fork
      run_frame(4, 4, 0, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (s.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("t2_first_seen", 144'(seen), 144'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("t2_hold_win", s.out_win, first_win);
          check("t2_hold_valid", 144'(s.out_valid), 144'd1);
          check("t2_hold_in_ready", 144'(s.in_ready), 144'd0);
        end
        @(posedge clk); #1;
        s.out_ready = 1'b1;
        @(negedge clk);
        check("t2_resume_in_ready", 144'(s.in_ready), 144'd1);
      end
    join
    wait_drain();
    check("t2_wins", 144'(win_cnt - base), 144'd4);

    // T3: full-width, 3-row frame with random back-pressure.
    base     = win_cnt;
    drv_done = 1'b0;
    do_start(MAX_W, 3);
    fork
      begin
        run_frame(MAX_W, 3, 1, 1'b0);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          s.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    s.out_ready = 1'b1;
    wait_drain();
    check("t3_wins", 144'(win_cnt - base), 144'(MAX_W - 2));

    // T4: rejected configurations.
    bad_start(2, 4);
    bad_start(4, MAX_H + 1);

    // T5: reset in the middle of a frame, then a fresh 5x3 frame.
    do_start(4, 4);
    for (int i = 0; i < 7; i++) send_pix(DW'(16'h0100 + i), i / 4, i % 4);
    s.in_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("t5_rst_out_valid", 144'(s.out_valid), 144'd0);
    check("t5_rst_busy", 144'(busy), 144'd0);
    check("t5_rst_in_ready", 144'(s.in_ready), 144'd0);
    check("t5_rst_out_win", s.out_win, 144'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = win_cnt;
    do_start(5, 3);
    run_frame(5, 3, 1, 1'b0);
    wait_drain();
    check("t5_wins", 144'(win_cnt - base), 144'd3);

    // T6: ignored mid-frame start, then a back-to-back frame.
    base = win_cnt;
    do_start(4, 4);
    run_frame(4, 4, 0, 1'b1);
    wait_drain();
    do_start(4, 4);
    run_frame(4, 4, 0, 1'b0);
    wait_drain();
    check("t6_wins", 144'(win_cnt - base), 144'd8);
    check("sb_empty", 144'(sb.size()), 144'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends even if stimulus wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
